// File: rtl/serv_fetch_if.sv
// serv_fetch_if: Wishbone classic read channel between the fetch stage and instruction memory.
interface serv_fetch_if;
    logic [31:0] adr;
    logic        cyc;
    logic [31:0] rdt;
    logic        ack;
    modport master (output adr, cyc, input rdt, ack);
    modport slave (input adr, cyc, output rdt, ack);
endinterface

// File: rtl/serv_fetch.sv
// serv_fetch: Wishbone classic instruction fetch feeding the decoder with a one-cycle strobe.
// Define SERV_FETCH_TIMEOUT_EN to add a TIMEOUT-cycle bus watchdog; otherwise a fetch waits forever.
module serv_fetch #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_fetch,
    input  logic [31:0]  i_pc,
    input  logic         i_flush,
    serv_fetch_if.master ibus,
    output logic [31:0]  o_dec_rdt,
    output logic         o_dec_en,
    output logic         o_ill,
    output logic         o_misalign,
    output logic         o_busy,
    output logic         o_bus_err
);
    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
    state_t state, state_n;
    logic cyc, cyc_n, pend, pend_n, ack, expire;
    logic dec_en_n, ill_n, misalign_n, bus_err_n;
    logic [31:0] adr, adr_n, dec_rdt_n, pend_pc, pend_pc_n;

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("serv_fetch: TIMEOUT must be within 2..65535");
    end

    // An ack is only meaningful while a cycle is open, so a late ack after reset is dropped.
    assign ack = ibus.ack && cyc;
    assign ibus.adr = adr;
    assign ibus.cyc = cyc;
    assign o_busy = state != IDLE;

`ifdef SERV_FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt;
    assign expire = cyc && !ack && cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (i_rst || !cyc || state_n != state) cnt <= '0;
        else if (!ack) cnt <= cnt + 1'b1;
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cyc_n = cyc;
        adr_n = adr;
        dec_rdt_n = o_dec_rdt;
        dec_en_n = 1'b0;
        ill_n = 1'b0;
        misalign_n = 1'b0;
        bus_err_n = 1'b0;
        pend_n = pend;
        pend_pc_n = pend_pc;
        case (state)
            IDLE: if (i_fetch) begin
                misalign_n = i_pc[1:0] != 2'b00;
                if (!misalign_n) begin
                    adr_n = {i_pc[31:2], 2'b00};
                    cyc_n = 1'b1;
                    state_n = WAIT;
                end
            end
            WAIT: if (ack) begin
                cyc_n = 1'b0;
                state_n = IDLE;
                dec_en_n = !i_flush;
                dec_rdt_n = i_flush ? o_dec_rdt : ibus.rdt;
                ill_n = !i_flush && ibus.rdt[1:0] != 2'b11;
            end else if (expire) begin
                cyc_n = 1'b0;
                bus_err_n = 1'b1;
                state_n = IDLE;
            end else begin
                // re-raises cyc after the idle gap that follows a drained transfer
                cyc_n = 1'b1;
                state_n = i_flush ? DRAIN : WAIT;
            end
            DRAIN: begin
                if (i_fetch) begin
                    pend_n = 1'b1;
                    pend_pc_n = i_pc;
                end
                if (ack || expire) begin
                    misalign_n = pend_n && pend_pc_n[1:0] != 2'b00;
                    state_n = (pend_n && !misalign_n) ? WAIT : IDLE;
                    adr_n = (state_n == WAIT) ? {pend_pc_n[31:2], 2'b00} : adr;
                    cyc_n = 1'b0;
                    pend_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= IDLE;
            cyc <= 1'b0;
            adr <= '0;
            o_dec_rdt <= '0;
            o_dec_en <= 1'b0;
            o_ill <= 1'b0;
            o_misalign <= 1'b0;
            o_bus_err <= 1'b0;
            pend <= 1'b0;
            pend_pc <= '0;
        end else begin
            state <= state_n;
            cyc <= cyc_n;
            adr <= adr_n;
            o_dec_rdt <= dec_rdt_n;
            o_dec_en <= dec_en_n;
            o_ill <= ill_n;
            o_misalign <= misalign_n;
            o_bus_err <= bus_err_n;
            pend <= pend_n;
            pend_pc <= pend_pc_n;
        end
    end
endmodule

// File: tb/tb_serv_fetch.sv
// tb_serv_fetch: directed fetch-stage bench; decoder strobes are checked against a queue of expected words.
module tb_serv_fetch;
    logic clk = 1'b0;
    logic rst, fetch, flush;
    logic [31:0] pc, dec_rdt;
    logic dec_en, ill, misalign, busy, bus_err;
    int checks = 0;
    int failures = 0;
    typedef struct { logic [31:0] rdt; logic ill; } exp_t;
    exp_t exp_q[$];

    serv_fetch_if bus();

    serv_fetch #(.TIMEOUT(8)) dut (
        .clk(clk), .i_rst(rst), .i_fetch(fetch), .i_pc(pc), .i_flush(flush), .ibus(bus),
        .o_dec_rdt(dec_rdt), .o_dec_en(dec_en), .o_ill(ill), .o_misalign(misalign),
        .o_busy(busy), .o_bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one clock; any queued word must appear as a strobe on exactly this cycle.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (dec_en || exp_q.size() != 0) begin
            chk1("dec_en", dec_en, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (dec_en) begin
                    chk("dec_rdt", dec_rdt, e.rdt);
                    chk1("dec_ill", ill, e.ill);
                end
            end
        end
    endtask

    task automatic ack_with(input logic [31:0] rdt, input bit deliver);
        exp_t e;
        bus.ack = 1'b1;
        bus.rdt = rdt;
        e.rdt = rdt;
        e.ill = rdt[1:0] != 2'b11;
        if (deliver) exp_q.push_back(e);
        step();
        bus.ack = 1'b0;
    endtask

    task automatic fetch_pc(input logic [31:0] a);
        fetch = 1'b1;
        pc = a;
        step();
        fetch = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; fetch = 1'b0; flush = 1'b0; pc = '0; bus.ack = 1'b0; bus.rdt = '0;
        step();
        step();
        rst = 1'b0;
        chk1("rst_cyc", bus.cyc, 1'b0);
        chk("rst_adr", bus.adr, 32'h0);
        chk("rst_dec_rdt", dec_rdt, 32'h0);
        chk1("rst_dec_en", dec_en, 1'b0);
        chk1("rst_ill", ill, 1'b0);
        chk1("rst_misalign", misalign, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        // basic fetch, ack on the fourth cyc cycle
        fetch_pc(32'h0000_0100);
        chk("t1_adr", bus.adr, 32'h0000_0100);
        for (int i = 0; i < 3; i++) begin
            chk1("t1_cyc_hold", bus.cyc, 1'b1);
            step();
        end
        chk1("t1_cyc_hold", bus.cyc, 1'b1);
        ack_with(32'h0050_0093, 1'b1);
        chk1("t1_cyc_drop", bus.cyc, 1'b0);
        chk1("t1_busy", busy, 1'b0);
        step();
        chk1("t1_strobe_once", dec_en, 1'b0);
        chk("t1_rdt_hold", dec_rdt, 32'h0050_0093);
        // misaligned PC
        fetch_pc(32'h0000_0102);
        chk1("t2_misalign", misalign, 1'b1);
        chk1("t2_cyc", bus.cyc, 1'b0);
        chk1("t2_busy", busy, 1'b0);
        step();
        chk1("t2_misalign_pulse", misalign, 1'b0);
        chk1("t2_cyc_after", bus.cyc, 1'b0);
        chk1("t2_busy_after", busy, 1'b0);
        chk("t2_adr_hold", bus.adr, 32'h0000_0100);
        // flush with a pending fetch in DRAIN
        fetch_pc(32'h0000_0200);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk1("t3_drain_cyc", bus.cyc, 1'b1);
        chk1("t3_drain_busy", busy, 1'b1);
        fetch_pc(32'h0000_0300);
        chk("t3_adr_pending", bus.adr, 32'h0000_0200);
        ack_with(32'hdead_beef, 1'b0);
        chk1("t3_cyc_gap", bus.cyc, 1'b0);
        chk("t3_adr_next", bus.adr, 32'h0000_0300);
        chk1("t3_busy_gap", busy, 1'b1);
        step();
        chk1("t3_cyc_restart", bus.cyc, 1'b1);
        ack_with(32'h0000_0013, 1'b1);
        chk1("t3_cyc_end", bus.cyc, 1'b0);
        // flush and ack together, then an illegal encoding
        fetch_pc(32'h0000_0400);
        flush = 1'b1; bus.ack = 1'b1; bus.rdt = 32'h1111_1113;
        step();
        flush = 1'b0; bus.ack = 1'b0;
        chk1("t4_busy", busy, 1'b0);
        chk1("t4_cyc", bus.cyc, 1'b0);
        chk("t4_rdt_hold", dec_rdt, 32'h0000_0013);
        fetch_pc(32'h0000_0500);
        ack_with(32'h0000_4501, 1'b1);
        // fetch+flush in IDLE is accepted
        fetch = 1'b1; flush = 1'b1; pc = 32'h0000_0600;
        step();
        fetch = 1'b0; flush = 1'b0;
        chk1("t4_ff_cyc", bus.cyc, 1'b1);
        chk("t4_ff_adr", bus.adr, 32'h0000_0600);
        // misaligned pending PC in DRAIN
        flush = 1'b1;
        step();
        flush = 1'b0;
        fetch_pc(32'h0000_0701);
        ack_with(32'h0000_0000, 1'b0);
        chk1("t4_pend_misalign", misalign, 1'b1);
        chk1("t4_pend_busy", busy, 1'b0);
        chk1("t4_pend_cyc", bus.cyc, 1'b0);
        // DRAIN without pending
        fetch_pc(32'h0000_0800);
        flush = 1'b1;
        step();
        flush = 1'b0;
        ack_with(32'h0000_0000, 1'b0);
        chk1("t4_nopend_busy", busy, 1'b0);
        chk1("t4_nopend_cyc", bus.cyc, 1'b0);
        chk("t4_nopend_adr", bus.adr, 32'h0000_0800);
        // later DRAIN fetch overwrites the pending PC
        fetch_pc(32'h0000_0a00);
        flush = 1'b1;
        step();
        flush = 1'b0;
        fetch_pc(32'h0000_0a01);
        fetch_pc(32'h0000_0a04);
        ack_with(32'h0000_0000, 1'b0);
        chk("t4_overwrite_adr", bus.adr, 32'h0000_0a04);
        chk1("t4_overwrite_misalign", misalign, 1'b0);
        step();
        ack_with(32'h0000_0033, 1'b1);
        // reset during WAIT, late ack ignored
        fetch_pc(32'h0000_0900);
        chk1("t5_cyc_before", bus.cyc, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk1("t5_cyc_at_rst", bus.cyc, 1'b0);
        bus.ack = 1'b1; bus.rdt = 32'h0000_0093;
        step();
        bus.ack = 1'b0;
        chk1("t5_cyc", bus.cyc, 1'b0);
        chk("t5_adr", bus.adr, 32'h0);
        chk("t5_dec_rdt", dec_rdt, 32'h0);
        chk1("t5_ill", ill, 1'b0);
        chk1("t5_misalign", misalign, 1'b0);
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_bus_err", bus_err, 1'b0);
`ifdef SERV_FETCH_TIMEOUT_EN
        fetch_pc(32'h0000_0b00);
        for (int i = 0; i < 7; i++) begin
            chk1("t6_cyc_hold", bus.cyc, 1'b1);
            chk1("t6_no_err", bus_err, 1'b0);
            step();
        end
        chk1("t6_cyc_hold", bus.cyc, 1'b1);
        step();
        chk1("t6_cyc_drop", bus.cyc, 1'b0);
        chk1("t6_bus_err", bus_err, 1'b1);
        chk1("t6_idle", busy, 1'b0);
        step();
        chk1("t6_bus_err_pulse", bus_err, 1'b0);
        fetch_pc(32'h0000_0c00);
        for (int i = 0; i < 7; i++) begin
            chk1("t6b_cyc_hold", bus.cyc, 1'b1);
            step();
        end
        ack_with(32'h00c0_0093, 1'b1);
        chk1("t6b_no_err", bus_err, 1'b0);
        chk1("t6b_cyc", bus.cyc, 1'b0);
`else
        fetch_pc(32'h0000_0b00);
        for (int i = 0; i < 20; i++) step();
        chk1("t6_cyc_waits", bus.cyc, 1'b1);
        chk1("t6_busy_waits", busy, 1'b1);
        chk1("t6_no_err", bus_err, 1'b0);
        ack_with(32'h00c0_0093, 1'b1);
        chk1("t6_cyc", bus.cyc, 1'b0);
`endif
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serv_fetch.md
Name: serv_fetch

Overview:
Instruction fetch stage directly upstream of the instruction decoder. Accepts a fetch request and PC from the control/state logic and runs one Wishbone classic read on the instruction bus. Delivers the fetched word to the decoder as a one-cycle data-plus-enable strobe. Also handles flushes on traps and redirects, and flags misaligned PCs and non-32-bit encodings.

Parameters:
TIMEOUT, 64, bus watchdog limit in cycles; used only with SERV_FETCH_TIMEOUT_EN; legal range 2..65535.

Ports:
clk  input  1  clock
i_rst  input  1  reset, synchronous, active-high
i_fetch  input  1  single-cycle fetch request
i_pc  input  32  fetch address, sampled when i_fetch is accepted
i_flush  input  1  discard any in-flight fetch
o_ibus_adr  output  32  Wishbone address, registered, always word-aligned
o_ibus_cyc  output  1  Wishbone cyc/stb
i_ibus_rdt  input  32  Wishbone read data
i_ibus_ack  input  1  Wishbone ack
o_dec_rdt  output  32  instruction word to the decoder (decoder uses [31:2])
o_dec_en  output  1  one-cycle strobe; o_dec_rdt is valid in the same cycle
o_ill  output  1  high with o_dec_en when o_dec_rdt[1:0] != 2'b11
o_misalign  output  1  one-cycle pulse when a misaligned PC is rejected
o_busy  output  1  high when the state is not IDLE
o_bus_err  output  1  one-cycle watchdog-abort pulse

Behaviour:
- Clocking and reset: single clock, reset synchronous active-high on clk.
- Reset values: state IDLE; o_ibus_cyc 0; o_ibus_adr 0; o_dec_rdt 0; o_dec_en 0; o_ill 0; o_misalign 0; o_bus_err 0; pending flag and pending address cleared.
- Reset mid-cycle: o_ibus_cyc drops at the reset edge; any late ack is ignored.
- States: IDLE, WAIT, DRAIN.
- IDLE, i_fetch with i_pc[1:0] == 0: o_ibus_adr <= {i_pc[31:2],2'b00}, o_ibus_cyc <= 1, go to WAIT. Request-to-cyc latency is 1 cycle.
- IDLE, i_fetch with i_pc[1:0] != 0: no bus cycle; o_misalign = 1 for the next cycle; stay in IDLE.
- IDLE, i_flush: no effect. i_fetch and i_flush together in IDLE: the fetch is accepted.
- WAIT, i_ibus_ack and no i_flush:
  - o_ibus_cyc <= 0, o_dec_rdt <= i_ibus_rdt, o_dec_en <= 1 for exactly 1 cycle, o_ill <= (i_ibus_rdt[1:0] != 2'b11).
  - Go to IDLE. Ack-to-o_dec_en latency is 1 cycle.
- WAIT, i_flush with no ack: keep o_ibus_cyc high (no bus abort), go to DRAIN.
- WAIT, i_flush and ack in the same cycle: data discarded, no o_dec_en, o_ibus_cyc <= 0, go to IDLE.
- WAIT, i_fetch: ignored (protocol violation; the bench asserts on it).
- DRAIN, i_fetch: latch pending = 1 and the pending PC. A later i_fetch in DRAIN overwrites the pending PC.
- DRAIN, ack: data discarded, no o_dec_en.
  - With pending and an aligned pending PC: o_ibus_cyc stays high and drops for exactly 1 cycle between the two transfers. o_ibus_adr <= pending PC, go to WAIT, clear pending.
  - With pending and a misaligned pending PC: o_misalign pulse, go to IDLE.
  - With no pending: o_ibus_cyc <= 0, go to IDLE.
- i_flush in DRAIN: no additional effect. Pending is not cleared by i_flush.
- o_dec_rdt holds its value between strobes.
- o_ibus_adr changes only on acceptance of a fetch.

Optional Feature:
SERV_FETCH_TIMEOUT_EN
- Defined:
  - A counter of width clog2(TIMEOUT) is cleared on every entry to WAIT or DRAIN and increments each cycle without ack.
  - When it reaches TIMEOUT-1 with no ack in that cycle: o_ibus_cyc <= 0.
  - From WAIT: o_bus_err pulses for 1 cycle, no o_dec_en, go to IDLE.
  - From DRAIN: no o_bus_err; follow the DRAIN ack rules, with pending honoured.
  - An ack in the same cycle as expiry wins; no error.
- Undefined: no counter is built, a fetch waits forever, and o_bus_err is tied to 0.

Test Plan:
1. Reset, then i_fetch with i_pc=0x0000_0100 and ack 3 cycles after cyc with rdt=0x0050_0093 -> adr=0x100; cyc high for 4 cycles; o_dec_en=1 for one cycle with o_dec_rdt=0x0050_0093 and o_ill=0.
2. i_fetch with i_pc=0x0000_0102 -> cyc never rises; o_misalign=1 for one cycle; o_busy=0 throughout.
3. Fetch 0x200; i_flush 1 cycle later; i_fetch 0x300 in DRAIN; ack on 0x200 -> no o_dec_en for 0x200; cyc low for 1 cycle then adr=0x300; ack with rdt=0x0000_0013 -> o_dec_en with 0x0000_0013.
4. Fetch with i_flush and ack in the same cycle -> no o_dec_en; o_busy=0 next cycle. Separately, ack rdt=0x0000_4501 -> o_dec_en=1 with o_ill=1.
5. i_rst asserted in WAIT, then ack one cycle later -> cyc=0 at the reset edge; no o_dec_en; all outputs at reset values.
6. With SERV_FETCH_TIMEOUT_EN and TIMEOUT=8, no ack -> cyc drops after 8 cycles; o_bus_err=1 for one cycle; state IDLE. Ack exactly at cycle 8 -> o_dec_en and no o_bus_err.
